// File: rtl/cpu_multicycle.sv
// Multi-cycle MIPS-subset core: START/FETCH/DECODE/EXEC/WB/HALT FSM over a req/ack instruction port.
// Build option: define CPU_BRANCH_EN to implement BEQ/BNE/J; otherwise those opcodes halt the core.
module cpu_multicycle #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset,
  output logic [XLEN-1:0] instr_addr,
  output logic            instr_req,
  input  logic            instr_ack,
  input  logic [31:0]     instr_in,
  output logic            retire,
  output logic            halted
);

  localparam int unsigned NREG     = 32;
  localparam logic [5:0]  OP_RTYPE = 6'h00;
  localparam logic [5:0]  OP_ADDI  = 6'h08;
`ifdef CPU_BRANCH_EN
  localparam logic [5:0]  OP_BEQ   = 6'h04;
  localparam logic [5:0]  OP_BNE   = 6'h05;
  localparam logic [5:0]  OP_J     = 6'h02;
`endif
  localparam logic [5:0]  FN_ADD   = 6'h20;
  localparam logic [5:0]  FN_SUB   = 6'h22;
  localparam logic [5:0]  FN_AND   = 6'h24;
  localparam logic [5:0]  FN_OR    = 6'h25;
  localparam logic [5:0]  FN_SLT   = 6'h2A;

  typedef enum logic [2:0] {S_START, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;

  state_t          state, state_nxt;
  logic            req_nxt, retire_nxt, halted_nxt;
  logic [31:0]     ir;
  logic [XLEN-1:0] a, b, alu, npc;
  logic [XLEN-1:0] rf [NREG];

  logic [5:0]      opcode, funct;
  logic [4:0]      rs, rt, rd, wr_addr_c;
  logic [15:0]     imm;
  logic [XLEN-1:0] simm, pc_plus4, alu_c, npc_c;
  logic            legal_c, wr_en_c;

  assign opcode   = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign imm      = ir[15:0];
  assign funct    = ir[5:0];
  assign simm     = {{(XLEN-16){imm[15]}}, imm};
  assign pc_plus4 = instr_addr + XLEN'(4);

  // Instruction legality, evaluated while the IR is stable in DECODE.
  always_comb begin
    legal_c = 1'b0;
    case (opcode)
      OP_RTYPE: legal_c = funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
      OP_ADDI:  legal_c = 1'b1;
`ifdef CPU_BRANCH_EN
      OP_BEQ, OP_BNE, OP_J: legal_c = 1'b1;
`endif
      default:  legal_c = 1'b0;
    endcase
  end

  always_comb begin
    alu_c = '0;
    if (opcode == OP_ADDI) begin
      alu_c = a + simm;
    end else begin
      case (funct)
        FN_ADD:  alu_c = a + b;
        FN_SUB:  alu_c = a - b;
        FN_AND:  alu_c = a & b;
        FN_OR:   alu_c = a | b;
        FN_SLT:  alu_c = XLEN'($signed(a) < $signed(b));
        default: alu_c = '0;
      endcase
    end
  end

  always_comb begin
    npc_c = pc_plus4;
`ifdef CPU_BRANCH_EN
    if ((opcode == OP_BEQ && a == b) || (opcode == OP_BNE && a != b)) begin
      npc_c = pc_plus4 + (simm << 2);
    end else if (opcode == OP_J) begin
      npc_c = {pc_plus4[XLEN-1:28], ir[25:0], 2'b00};
    end
`endif
  end

  always_comb begin
    wr_en_c   = 1'b0;
    wr_addr_c = rd;
    if (opcode == OP_RTYPE) begin
      wr_en_c = 1'b1;
    end else if (opcode == OP_ADDI) begin
      wr_en_c   = 1'b1;
      wr_addr_c = rt;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_START;
      instr_req <= 1'b0;
      retire    <= 1'b0;
      halted    <= 1'b0;
    end else begin
      state     <= state_nxt;
      instr_req <= req_nxt;
      retire    <= retire_nxt;
      halted    <= halted_nxt;
    end
  end

  // Outputs are registered copies of the next state's flags.
  always_comb begin
    state_nxt = state;
    case (state)
      S_START:  state_nxt = S_FETCH;
      S_FETCH:  if (instr_ack) state_nxt = S_DECODE;
      S_DECODE: state_nxt = legal_c ? S_EXEC : S_HALT;
      S_EXEC:   state_nxt = S_WB;
      S_WB:     state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_HALT;
    endcase
    req_nxt    = (state_nxt == S_FETCH);
    retire_nxt = (state_nxt == S_WB);
    halted_nxt = (state_nxt == S_HALT);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      instr_addr <= RESET_PC;
      ir         <= '0;
      a          <= '0;
      b          <= '0;
      alu        <= '0;
      npc        <= '0;
    end else begin
      case (state)
        S_FETCH:  if (instr_ack) ir <= instr_in;
        S_DECODE: begin
          a <= rf[rs];
          b <= rf[rt];
        end
        S_EXEC: begin
          alu <= alu_c;
          npc <= npc_c;
        end
        S_WB:     instr_addr <= npc;
        default:  ;
      endcase
    end
  end

  // r0 is never written, so it always reads back as zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rf <= '{default: '0};
    end else if (state == S_WB && wr_en_c && wr_addr_c != 5'd0) begin
      rf[wr_addr_c] <= alu;
    end
  end

endmodule

// File: tb/tb_cpu_multicycle.sv
// Bench for cpu_multicycle: ISA-level interpreter predicts fetch addresses, halt point and registers.
module tb_cpu_multicycle;

  localparam int unsigned MEM_WORDS    = 64;
  localparam logic [31:0] HALT_WORD    = 32'hFC00_0000;
  localparam int          CYCLE_BUDGET = 3000;

  logic        clock, reset, instr_req, instr_ack, retire, halted;
  logic [31:0] instr_addr, instr_in;

  logic [31:0] mem [MEM_WORDS];
  logic [31:0] exp_pcs [$];
  logic [31:0] exp_regs [32];
  logic [31:0] exp_halt_pc;
  int          n_checks, n_pass;
  bit          branch_en;

  cpu_multicycle #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clock      (clock),
    .reset      (reset),
    .instr_addr (instr_addr),
    .instr_req  (instr_req),
    .instr_ack  (instr_ack),
    .instr_in   (instr_in),
    .retire     (retire),
    .halted     (halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] fetch_word(input logic [31:0] addr);
    if (addr < 32'(MEM_WORDS * 4)) return mem[addr[7:2]];
    return HALT_WORD;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] = HALT_WORD;
  endtask

  // Plain instruction-at-a-time interpreter of the ISA rules.
  task automatic build_model();
    logic [31:0] pc, pc4, nxt, ins, a, b, sx, res;
    logic [31:0] r [32];
    logic [4:0]  dst;
    bit          legal, wr;
    for (int i = 0; i < 32; i++) r[i] = '0;
    pc = 32'h0;
    exp_halt_pc = 32'hFFFF_FFFF;
    exp_pcs.delete();
    for (int n = 0; n < 500; n++) begin
      exp_pcs.push_back(pc);
      ins = fetch_word(pc);
      a = r[ins[25:21]];
      b = r[ins[20:16]];
      sx = {{16{ins[15]}}, ins[15:0]};
      pc4 = pc + 32'd4;
      nxt = pc4;
      legal = 1'b1; wr = 1'b0; dst = 5'd0; res = '0;
      case (ins[31:26])
        6'h00: begin
          wr = 1'b1; dst = ins[15:11];
          case (ins[5:0])
            6'h20:   res = a + b;
            6'h22:   res = a - b;
            6'h24:   res = a & b;
            6'h25:   res = a | b;
            6'h2A:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: legal = 1'b0;
          endcase
        end
        6'h08: begin wr = 1'b1; dst = ins[20:16]; res = a + sx; end
        6'h04: begin legal = branch_en; if (a == b) nxt = pc4 + (sx << 2); end
        6'h05: begin legal = branch_en; if (a != b) nxt = pc4 + (sx << 2); end
        6'h02: begin legal = branch_en; nxt = {pc4[31:28], ins[25:0], 2'b00}; end
        default: legal = 1'b0;
      endcase
      if (!legal) begin
        exp_halt_pc = pc;
        break;
      end
      if (wr && dst != 5'd0) r[dst] = res;
      pc = nxt;
    end
    for (int i = 0; i < 32; i++) exp_regs[i] = r[i];
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    instr_ack = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  // Serves fetches with random wait states and checks against the model; starts from START.
  task automatic run_program(input int max_delay, input string tag);
    int idx, cyc, waits, delay, nret;
    idx = 0; cyc = 0; waits = 0; nret = 0;
    delay = int'($urandom_range(max_delay, 0));
    while (cyc < CYCLE_BUDGET) begin
      @(posedge clock);
      cyc++;
      @(negedge clock);
      if (retire) begin
        nret++;
        if (max_delay == 0) begin
          n_checks++;
          if (cyc !== 4 * nret) $display("FAIL %s retire_cycle got %0d want %0d", tag, cyc, 4 * nret);
          else n_pass++;
        end
      end
      if (halted) break;
      if (instr_req) begin
        n_checks++;
        if (idx >= exp_pcs.size()) $display("FAIL %s extra_fetch got addr %h want none", tag, instr_addr);
        else if (instr_addr !== exp_pcs[idx]) $display("FAIL %s fetch_addr got %h want %h", tag, instr_addr, exp_pcs[idx]);
        else n_pass++;
        if (waits >= delay) begin
          instr_ack = 1'b1;
          instr_in = fetch_word(instr_addr);
          idx++;
          waits = 0;
          delay = int'($urandom_range(max_delay, 0));
        end else begin
          instr_ack = 1'b0;
          instr_in = $urandom;
          waits++;
        end
      end else begin
        instr_ack = 1'($urandom_range(1, 0));
        instr_in = $urandom;
      end
    end
    n_checks++;
    if (halted !== 1'b1) $display("FAIL %s halt_timeout got halted=%b want 1", tag, halted);
    else n_pass++;
    n_checks++;
    if (idx !== exp_pcs.size()) $display("FAIL %s fetch_count got %0d want %0d", tag, idx, exp_pcs.size());
    else n_pass++;
    n_checks++;
    if (nret !== exp_pcs.size() - 1) $display("FAIL %s retire_count got %0d want %0d", tag, nret, exp_pcs.size() - 1);
    else n_pass++;
    for (int i = 0; i < 32; i++) begin
      n_checks++;
      if (dut.rf[i] !== exp_regs[i]) $display("FAIL %s reg r%0d got %h want %h", tag, i, dut.rf[i], exp_regs[i]);
      else n_pass++;
    end
    repeat (8) begin
      @(negedge clock);
      instr_ack = 1'($urandom_range(1, 0));
      n_checks++;
      if ({instr_req, retire, halted} !== 3'b001 || instr_addr !== exp_halt_pc)
        $display("FAIL %s halt_hold got req/ret/hlt=%b addr=%h want 001 addr=%h",
                 tag, {instr_req, retire, halted}, instr_addr, exp_halt_pc);
      else n_pass++;
    end
    instr_ack = 1'b0;
  endtask

  task automatic load_alu_prog();
    clear_mem();
    mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    mem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
    mem[2] = enc_r(6'h20, 5'd3, 5'd1, 5'd2);
    mem[3] = enc_r(6'h22, 5'd4, 5'd2, 5'd1);
    mem[4] = enc_r(6'h2A, 5'd5, 5'd2, 5'd1);
    mem[5] = enc_r(6'h25, 5'd6, 5'd1, 5'd2);
    mem[6] = enc_i(6'h08, 5'd0, 5'd0, 16'd7);
    mem[7] = enc_r(6'h24, 5'd7, 5'd1, 5'd2);
  endtask

  task automatic check_alu_consts(input string tag);
    logic [31:0] want [8];
    want = '{32'h0, 32'h5, 32'hFFFF_FFFD, 32'h2, 32'hFFFF_FFF8, 32'h1, 32'hFFFF_FFFD, 32'h5};
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (dut.rf[i] !== want[i]) $display("FAIL %s alu_r%0d got %h want %h", tag, i, dut.rf[i], want[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_fetch();
    clear_mem();
    mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
    mem[1] = enc_i(6'h08, 5'd1, 5'd2, 16'd2);
    @(negedge clock);
    reset = 1'b0;
    instr_ack = 1'b1;
    repeat (3) begin
      @(negedge clock);
      n_checks++;
      if ({instr_req, retire, halted} !== 3'b000 || instr_addr !== 32'h0)
        $display("FAIL reset_state got req/ret/hlt=%b addr=%h want 000 addr=0",
                 {instr_req, retire, halted}, instr_addr);
      else n_pass++;
    end
    instr_ack = 1'b0;
    reset = 1'b1;
    build_model();
    run_program(0, "reset_fetch");
    n_checks++;
    if (instr_addr !== 32'h8) $display("FAIL illegal_halt_addr got %h want 00000008", instr_addr);
    else n_pass++;
  endtask

  task automatic test_alu();
    load_alu_prog();
    do_reset();
    build_model();
    run_program(0, "alu");
    check_alu_consts("alu");
  endtask

  task automatic test_wait_states();
    load_alu_prog();
    do_reset();
    build_model();
    run_program(7, "wait_states");
    check_alu_consts("wait_states");
  endtask

  task automatic test_branch();
    clear_mem();
    mem[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
    mem[1]  = enc_i(6'h04, 5'd1, 5'd1, 16'd2);
    mem[4]  = {6'h02, 26'h10};
    mem[16] = enc_i(6'h05, 5'd0, 5'd0, 16'd5);
    mem[17] = enc_i(6'h08, 5'd0, 5'd2, 16'h77);
    do_reset();
    build_model();
    run_program(0, "branch");
    n_checks++;
`ifdef CPU_BRANCH_EN
    if (instr_addr !== 32'h48 || dut.rf[2] !== 32'h77)
      $display("FAIL branch_end got addr=%h r2=%h want addr=00000048 r2=00000077", instr_addr, dut.rf[2]);
    else n_pass++;
`else
    if (instr_addr !== 32'h4 || dut.rf[1] !== 32'h1)
      $display("FAIL branch_disabled got addr=%h r1=%h want addr=00000004 r1=00000001", instr_addr, dut.rf[1]);
    else n_pass++;
`endif
  endtask

  task automatic test_random();
    logic [5:0] fns [5];
    int n;
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    for (int iter = 0; iter < 3; iter++) begin
      clear_mem();
      n = int'($urandom_range(30, 12));
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(1, 0) == 0)
          mem[k] = enc_i(6'h08, 5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)), 16'($urandom));
        else
          mem[k] = enc_r(fns[$urandom_range(4, 0)], 5'($urandom_range(7, 0)),
                         5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)));
      end
      mem[n] = ($urandom_range(1, 0) == 0) ? HALT_WORD : enc_r(6'h21, 5'd1, 5'd2, 5'd3);
      do_reset();
      build_model();
      run_program((iter == 0) ? 0 : 7, "random");
    end
  endtask

  task automatic test_async_reset();
    clear_mem();
    mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd9);
    do_reset();
    @(negedge clock);
    instr_ack = 1'b1;
    instr_in = mem[0];
    @(negedge clock);
    instr_ack = 1'b0;
    @(negedge clock);
    n_checks++;
    if (dut.rf[1] !== 32'h0 || instr_req !== 1'b0)
      $display("FAIL exec_pre_reset got r1=%h req=%b want r1=0 req=0", dut.rf[1], instr_req);
    else n_pass++;
    #1 reset = 1'b0;
    #1;
    n_checks++;
    if (dut.rf[1] !== 32'h0 || instr_addr !== 32'h0 || {instr_req, retire, halted} !== 3'b000)
      $display("FAIL mid_exec_reset got r1=%h addr=%h req/ret/hlt=%b want r1=0 addr=0 000",
               dut.rf[1], instr_addr, {instr_req, retire, halted});
    else n_pass++;
    #2 reset = 1'b1;
    build_model();
    run_program(0, "async_reset");
    n_checks++;
    if (dut.rf[1] !== 32'd9) $display("FAIL restart_r1 got %h want 00000009", dut.rf[1]);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
`ifdef CPU_BRANCH_EN
    branch_en = 1'b1;
`else
    branch_en = 1'b0;
`endif
    reset = 1'b0;
    instr_ack = 1'b0;
    instr_in = '0;
    test_reset_fetch();
    test_alu();
    test_wait_states();
    test_branch();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_multicycle.md
# cpu_multicycle

Parametrised multi-cycle successor to the single-cycle core: fetches one instruction per pass over a req/ack instruction port and executes a MIPS integer subset through an explicit FSM (FETCH, DECODE, EXEC, WB). It contains its own program counter, a 32-entry register file and an ALU. Datapath width is configurable. It sits between the instruction memory and the test harness, replacing the free-running PC+4 core.

## Interface
- XLEN, 32: datapath, register and PC width; legal values 32 or 64.
- RESET_PC, 0: PC value loaded on reset (XLEN bits, word aligned).

- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- instr_addr  out  XLEN  current PC; stable during FETCH.
- instr_req  out  1  fetch request; high only in FETCH.
- instr_ack  in  1  instruction valid; sampled only in FETCH.
- instr_in  in  32  instruction word; sampled on the edge where instr_req & instr_ack.
- retire  out  1  one-cycle pulse per completed instruction (WB).
- halted  out  1  sticky; high in HALT.

## Operation
- Fields: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0], imm[15:0], target[25:0].
- R-type (opcode 0x00): rd <= rs op rt. Funct 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT (signed, result 1 or 0). Any other funct is illegal.
- ADDI (0x08): rt <= rs + sext(imm).
- BEQ (0x04) / BNE (0x05): if the condition holds, PC <= PC+4 + (sext(imm)<<2); otherwise PC <= PC+4.
- J (0x02): PC <= {(PC+4)[XLEN-1:28], target, 2'b00}.
- All arithmetic is modulo 2^XLEN. There is no overflow trap.
- Register 0 reads as 0, and writes to it are discarded.
- An illegal opcode or funct enters HALT: no register write, PC frozen at the offending address, retire not pulsed.
- FSM states:
  - START (the reset state) -> FETCH.
  - FETCH: waits for instr_ack, latches IR -> DECODE.
  - DECODE: latches A=R[rs], B=R[rt], goes to HALT if illegal -> EXEC.
  - EXEC: latches ALU result and next PC -> WB.
  - WB: writes the register, updates the PC, pulses retire -> FETCH.
  - HALT: absorbing; only reset leaves it.

## Timing
- Reset values (while reset low): PC=RESET_PC, state=START, all 32 registers 0, instr_req=0, retire=0, halted=0. All outputs are registered.
- instr_req rises on the first rising edge after reset deasserts (START->FETCH). It stays high until the edge on which instr_ack is sampled high.
- instr_ack arriving on the same edge as instr_req rising is not a valid handshake, because req was not yet high at that edge. The minimum fetch is 1 cycle with req high.
- Latency per instruction is 4 cycles plus fetch wait states. With zero-wait ack, retire pulses every 4th cycle.
- The new PC appears on instr_addr in the cycle after WB, coincident with instr_req high.
- Register write-back is visible to the next instruction's DECODE, so there are no hazards.
- instr_ack outside FETCH is ignored, and instr_in is don't-care outside the handshake edge.
- Reset asserted mid-instruction aborts it immediately. There is no partial register write, and the block restarts from RESET_PC.
- PC wrap: PC+4 at 2^XLEN-4 wraps to 0 without error.

## Configuration
- CPU_BRANCH_EN defined: BEQ, BNE and J decode and execute as above.
- CPU_BRANCH_EN undefined: opcodes 0x04, 0x05 and 0x02 are illegal and enter HALT. Branch-target adders and the comparator are not built. PC is always PC+4.

## Test plan
- Reset and fetch:
  - Stimulus: hold reset low 3 cycles, release, ack immediately.
  - Required: instr_req=0 during reset; instr_addr=0; retire after 4 cycles per instruction; instr_addr sequence 0, 4, 8.
- ALU ops:
  - Program: ADDI r1,r0,5; ADDI r2,r0,-3; ADD r3,r1,r2; SUB r4,r2,r1; SLT r5,r2,r1; OR r6,r1,r2.
  - Required: r3=2, r4=0xFFFFFFF8, r5=1, r6=0xFFFFFFFD; ADDI r0,r0,7 leaves r0=0.
- Branch/jump (CPU_BRANCH_EN):
  - Program at 0x0: ADDI r1,r0,1; BEQ r1,r1,+2; …; J 0x40>>2.
  - Required: PC goes 0x0, 0x4, 0x10, then 0x40.
  - Not-taken BNE r0,r0 falls through to +4.
- Wait states:
  - Stimulus: delay instr_ack 0–7 random cycles.
  - Required: instr_req held high and instr_addr stable until ack; results identical to zero-wait.
- Illegal and halt:
  - Stimulus: instruction 0xFC000000 at 0x8.
  - Required: halted=1, instr_addr=0x8, no further instr_req or retire.
  - Compiled without CPU_BRANCH_EN, BEQ also halts.
- Async reset mid-EXEC:
  - Stimulus: pulse reset low for half a cycle during ADDI r1,r0,9.
  - Required: r1 stays 0; instr_addr returns to RESET_PC; execution restarts cleanly.
